// File: rtl/sar_adc_ctrl_if.sv
// Signal bundle between the SAR controller and its surroundings: the DAC code and
// S/H strobe, the comparator input, and the conversion request/result lines.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             EN;
  logic             start;
  logic             comp_in;
  logic [WIDTH-1:0] D;
  logic             sample;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             valid;

  // Handshake: start is looked at only while busy is low (IDLE). busy rises on the
  // edge that accepts start and falls on the edge that raises done; done is a
  // one-cycle pulse, dout holds the result until the next done, and valid stays
  // set once any conversion has completed. EN low cancels without a done.
  modport master (
    output EN, start, comp_in,
    input  D, sample, busy, done, dout, valid
  );

  modport slave (
    input  EN, start, comp_in,
    output D, sample, busy, done, dout, valid
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller driving a WIDTH-bit DAC and a comparator.
// Optional macro SAR_ADC_AVG4_EN: one start runs four conversions and reports their rounded mean.
module sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  sar_adc_ctrl_if.slave        bus,
  output logic [1:0]           dbg_state
);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic             sample_q, sample_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] dout_q, dout_n;
  logic             valid_q, valid_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [BW-1:0]    bit_q, bit_n;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] kept;

  // mask marks the bit on trial; kept is the code after this bit's decision.
  assign mask = {{(WIDTH-1){1'b0}}, 1'b1} << bit_q;
  assign kept = bus.comp_in ? d_q : (d_q & ~mask);

`ifdef SAR_ADC_AVG4_EN
  logic [WIDTH+1:0] acc_q, acc_n;
  logic [1:0]       run_q, run_n;
  logic [WIDTH+2:0] sum_w;
  logic [WIDTH:0]   avg_w;

  assign sum_w = {1'b0, acc_q} + {3'b000, kept};
  assign avg_w = (WIDTH+1)'((sum_w + (WIDTH+3)'(2)) >> 2);
`endif

  always_comb begin
    state_n  = state_q;
    d_n      = d_q;
    sample_n = sample_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    dout_n   = dout_q;
    valid_n  = valid_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
`ifdef SAR_ADC_AVG4_EN
    acc_n    = acc_q;
    run_n    = run_q;
`endif
    case (state_q)
      IDLE: begin
        d_n      = '0;
        sample_n = 1'b0;
        busy_n   = 1'b0;
        if (bus.EN && bus.start) begin
          state_n  = SAMPLE;
          sample_n = 1'b1;
          busy_n   = 1'b1;
          cnt_n    = 4'(SAMPLE_CYCLES - 1);
`ifdef SAR_ADC_AVG4_EN
          acc_n    = '0;
          run_n    = '0;
`endif
        end
      end
      SAMPLE: begin
        if (!bus.EN) begin
          state_n  = IDLE;
          d_n      = '0;
          sample_n = 1'b0;
          busy_n   = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_n  = CONVERT;
          sample_n = 1'b0;
          bit_n    = BW'(WIDTH - 1);
          d_n      = {1'b1, {(WIDTH-1){1'b0}}};
          cnt_n    = 4'(SETTLE_CYCLES);
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      CONVERT: begin
        if (!bus.EN) begin
          state_n  = IDLE;
          d_n      = '0;
          sample_n = 1'b0;
          busy_n   = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_n = cnt_q - 4'd1;
        end else if (bit_q != '0) begin
          d_n   = kept | (mask >> 1);
          bit_n = bit_q - 1'b1;
          cnt_n = 4'(SETTLE_CYCLES);
        end else begin
`ifdef SAR_ADC_AVG4_EN
          if (run_q != 2'd3) begin
            // Next pass of the average starts sampling immediately, no IDLE gap.
            acc_n    = sum_w[WIDTH+1:0];
            run_n    = run_q + 2'd1;
            state_n  = SAMPLE;
            sample_n = 1'b1;
            d_n      = '0;
            cnt_n    = 4'(SAMPLE_CYCLES - 1);
          end else begin
            dout_n  = avg_w[WIDTH] ? {WIDTH{1'b1}} : avg_w[WIDTH-1:0];
            done_n  = 1'b1;
            valid_n = 1'b1;
            busy_n  = 1'b0;
            d_n     = '0;
            state_n = IDLE;
          end
`else
          dout_n  = kept;
          done_n  = 1'b1;
          valid_n = 1'b1;
          busy_n  = 1'b0;
          d_n     = '0;
          state_n = IDLE;
`endif
        end
      end
      default: begin
        state_n  = IDLE;
        d_n      = '0;
        sample_n = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      d_q      <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
`ifdef SAR_ADC_AVG4_EN
      acc_q    <= '0;
      run_q    <= '0;
`endif
    end else begin
      state_q  <= state_n;
      d_q      <= d_n;
      sample_q <= sample_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      dout_q   <= dout_n;
      valid_q  <= valid_n;
      cnt_q    <= cnt_n;
      bit_q    <= bit_n;
`ifdef SAR_ADC_AVG4_EN
      acc_q    <= acc_n;
      run_q    <= run_n;
`endif
    end
  end

  assign bus.D      = d_q;
  assign bus.sample = sample_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.dout   = dout_q;
  assign bus.valid  = valid_q;
  assign dbg_state  = state_q;
endmodule
